// File: rtl/vga_mem_pkg.sv
// Shared types and constants for the VGA video-RAM arbiter.
// Video RAM map: font words 0x000-0x7FF, screen words 0x800-0xFFF.
package vga_mem_pkg;

  localparam int AW_DEF = 12;
  localparam int DW_DEF = 16;

  localparam logic [11:0] FONT_BASE   = 12'h000;
  localparam logic [11:0] SCREEN_BASE = 12'h800;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_t;

endpackage

// File: rtl/vga_mem_arbiter.sv
// Shares one single-port video RAM between the VGA master (absolute priority) and a CPU cs/ack port.
// Optional sticky protocol-conflict flag when VGA_ARB_CONFLICT_CHECK_EN is defined.
module vga_mem_arbiter
  import vga_mem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic [AW-1:0] i_vga_addr,
  input  logic          i_vga_cs,
  input  logic          i_vga_access,
  output logic [DW-1:0] o_vga_dat,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [DW-1:0] i_cpu_dat,
  input  logic          i_cpu_cs,
  input  logic          i_cpu_we,
  output logic [DW-1:0] o_cpu_dat,
  output logic          o_cpu_ack,
`ifdef VGA_ARB_CONFLICT_CHECK_EN
  output logic          o_conflict,
`endif
  output logic [AW-1:0] o_ram_addr,
  output logic [DW-1:0] o_ram_dat,
  output logic          o_ram_cs,
  output logic          o_ram_we,
  input  logic [DW-1:0] i_ram_dat
);

  state_t        r_state;
  logic [AW-1:0] r_cpu_addr;
  logic [DW-1:0] r_cpu_wdat;
  logic          r_cpu_we;
  logic [DW-1:0] r_cpu_rdat;
  logic          r_cpu_ack;
  logic          w_grant;

  assign w_grant = (r_state == GRANT);

  // CPU request is latched on grant so a cs drop during GRANT cannot corrupt the op.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= IDLE;
      r_cpu_addr <= '0;
      r_cpu_wdat <= '0;
      r_cpu_we   <= 1'b0;
      r_cpu_rdat <= '0;
      r_cpu_ack  <= 1'b0;
    end else begin
      r_cpu_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_cpu_cs && !i_vga_access) begin
            r_state    <= GRANT;
            r_cpu_addr <= i_cpu_addr;
            r_cpu_wdat <= i_cpu_dat;
            r_cpu_we   <= i_cpu_we;
          end
        end
        GRANT: begin
          if (i_vga_cs) begin
            r_state <= IDLE;
          end else begin
            r_state   <= ACK;
            r_cpu_ack <= 1'b1;
          end
        end
        ACK: begin
          r_state <= IDLE;
          if (!r_cpu_we) r_cpu_rdat <= i_ram_dat;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_ram_addr = r_cpu_addr;
    o_ram_dat  = r_cpu_wdat;
    o_ram_cs   = 1'b0;
    o_ram_we   = 1'b0;
    if (i_reset_n) begin
      if (i_vga_cs) begin
        o_ram_addr = i_vga_addr;
        o_ram_cs   = 1'b1;
      end else if (w_grant) begin
        o_ram_cs = 1'b1;
        o_ram_we = r_cpu_we;
      end
    end
  end

  assign o_vga_dat = i_ram_dat;
  assign o_cpu_ack = r_cpu_ack;
  // RAM data arrives during ACK: bypass it then, and hold the captured word afterwards.
  assign o_cpu_dat = (r_state == ACK && !r_cpu_we) ? i_ram_dat : r_cpu_rdat;

`ifdef VGA_ARB_CONFLICT_CHECK_EN
  logic r_vga_access_q;
  logic r_conflict;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_vga_access_q <= 1'b0;
      r_conflict     <= 1'b0;
    end else begin
      r_vga_access_q <= i_vga_access;
      if (i_vga_cs && (!r_vga_access_q || w_grant)) r_conflict <= 1'b1;
    end
  end

  assign o_conflict = r_conflict;
`endif

endmodule
